debug_frame_rx: RTL and testbench
=================================

// Module: debug_frame_rx
// PURPOSE
//   Receive-side counterpart of the debugger TX serializer. Consumes bytes from the UART
//   receiver (r_data/rx_ready/rd_uart handshake), frames them as SYNC + payload + XOR
//   checksum, and reassembles the payload into a wide parallel word (e.g. a debug bus image
//   or a register/memory preload). Sits between the UART unit and any consumer of a full frame.
// PARAMETERS
//   FRAME_BYTES     217   payload bytes per frame; FRAME_BITS = 8*FRAME_BYTES
//   SYNC_BYTE       8'hA5 frame start marker
//   TIMEOUT_CYCLES  50000 maximum clock cycles allowed between bytes inside a frame (>=2)
// PORTS
//   clock        in   1           system clock; all logic on the rising edge
//   reset        in   1           synchronous, active-high
//   r_data       in   8           received byte from UART; valid while rx_ready=1
//   rx_ready     in   1           UART holds a byte; stays high until consumed
//   rd_uart      out  1           one-cycle pulse: byte consumed
//   frame_data   out  FRAME_BITS  last good payload; first received byte in the MSBs
//   frame_valid  out  1           one-cycle pulse: frame_data just updated
//   frame_err    out  1           one-cycle pulse: checksum mismatch or timeout
//   busy         out  1           high in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE; rd_uart, frame_valid, frame_err, busy = 0; frame_data = 0.
//     Shift register, checksum, byte index and timeout counter = 0.
//     Reset mid-frame aborts the frame silently: no frame_err pulse.
//   Byte accept: a byte is accepted in any cycle with rx_ready=1 and rd_uart=0 (registered);
//     r_data is captured and rd_uart=1 in the next cycle. The cycle with rd_uart=1 never
//     accepts, so a rx_ready held high yields at most one accept every 2 cycles.
//   FSM:
//     IDLE    : accepted byte == SYNC_BYTE -> PAYLOAD; clear idx, chk, timer.
//               Any other byte is consumed (rd_uart pulses) and dropped.
//     PAYLOAD : each accept: shreg <= {shreg[FRAME_BITS-9:0], r_data};
//               chk <= chk ^ r_data; idx++.
//               On accept with idx == FRAME_BYTES-1 -> CHECK.
//               SYNC_BYTE values here are treated as data.
//     CHECK   : on accept, if r_data == chk: frame_data <= shreg, frame_valid=1 next cycle.
//               Otherwise frame_err=1 next cycle and frame_data is unchanged. Then -> IDLE.
//   Timeout: in PAYLOAD/CHECK the timer increments every cycle without an accept and clears
//     on an accept. When the timer reaches TIMEOUT_CYCLES-1: frame_err pulse, -> IDLE.
//     An accept in that same cycle wins (the byte is processed, no timeout).
//     No timeout in IDLE.
//   Widths: idx is clog2(FRAME_BYTES+1) bits; timer is clog2(TIMEOUT_CYCLES) bits and
//     saturates (never wraps). chk is 8 bits, initialised to 8'h00 at SYNC.
//   Latency: checksum accept -> frame_valid/frame_err exactly 1 cycle. frame_valid and
//     frame_err are never high together. frame_data is stable except on frame_valid.
//   busy = (state != IDLE), registered with the state.
// TESTING  (bench uses FRAME_BYTES=4, TIMEOUT_CYCLES=20)
//   1 Send A5 11 22 33 44 44 -> rd_uart pulses 6 times; frame_valid 1 cycle after the last
//     accept; frame_data = 32'h11223344; frame_err stays 0.
//   2 Send A5 11 22 33 44 45 -> frame_err pulse; frame_valid stays 0;
//     frame_data keeps its previous value.
//   3 Send 00 FF 3C then A5 01 02 03 04 04 -> the first 3 bytes are consumed and dropped;
//     frame_data = 32'h01020304, frame_valid pulse.
//   4 Send A5 01, then idle for 20 cycles -> frame_err pulse; busy returns to 0.
//     Then send a full good frame -> it is accepted normally.
//   5 Hold rx_ready=1 continuously across a full frame -> accepts on alternate cycles only;
//     result identical to scenario 1.
//   6 Assert reset after A5 11 22 -> busy=0, frame_data=0, no frame_err.
//     Then A5 AA BB CC DD 00 -> frame_data = 32'hAABBCCDD.

Source files
------------

// File: rtl/debug_frame_rx_if.sv
// UART receive handshake between the byte receiver (master) and a frame consumer (slave).
interface debug_frame_rx_if;
  logic [7:0] r_data;
  logic       rx_ready;
  logic       rd_uart;

  modport master (output r_data, output rx_ready, input rd_uart);
  modport slave  (input r_data, input rx_ready, output rd_uart);
endinterface

// File: rtl/debug_frame_rx.sv
// Frames UART bytes as SYNC + payload + XOR checksum and publishes the payload as one wide word.
//
// state   | meaning
// IDLE    | hunting for SYNC_BYTE, other bytes are consumed and dropped
// PAYLOAD | shifting in FRAME_BYTES payload bytes, accumulating the XOR checksum
// CHECK   | next byte is the checksum; publish frame_data or flag frame_err
module debug_frame_rx #(
  parameter int          FRAME_BYTES    = 217,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  debug_frame_rx_if.slave          uart,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     frame_valid,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int FRAME_BITS = 8 * FRAME_BYTES;
  localparam int IDX_W      = $clog2(FRAME_BYTES + 1);
  localparam int TMR_W      = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  state_t                 state;
  logic [FRAME_BITS-1:0]  shreg;
  logic [7:0]             chk;
  logic [IDX_W-1:0]       idx;
  logic [TMR_W-1:0]       timer;
  logic                   accept;

  // The cycle after an accept (rd_uart high) never accepts, giving the UART time to drop rx_ready.
  assign accept = uart.rx_ready && !uart.rd_uart;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      shreg       <= '0;
      chk         <= '0;
      idx         <= '0;
      timer       <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      uart.rd_uart <= 1'b0;
    end else begin
      uart.rd_uart <= accept;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept && uart.r_data == SYNC_BYTE) begin
            state <= S_PAYLOAD;
            busy  <= 1'b1;
            idx   <= '0;
            chk   <= '0;
            timer <= '0;
          end
        end

        S_PAYLOAD: begin
          if (accept) begin
            shreg <= {shreg[FRAME_BITS-9:0], uart.r_data};
            chk   <= chk ^ uart.r_data;
            idx   <= idx + 1'b1;
            timer <= '0;
            if (idx == IDX_LAST) state <= S_CHECK;
          end else if (timer == TMR_LAST) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end else if (timer != TMR_MAX) begin
            timer <= timer + 1'b1;
          end
        end

        S_CHECK: begin
          if (accept) begin
            if (uart.r_data == chk) begin
              frame_data  <= shreg;
              frame_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            timer <= '0;
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (timer == TMR_LAST) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end else if (timer != TMR_MAX) begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_rx.sv
// Directed bench for debug_frame_rx with a UART byte driver and an expected-frame scoreboard.
module tb_debug_frame_rx;

  localparam int FB = 4;
  localparam int TO = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        frame_err;
  logic        busy;

  debug_frame_rx_if u_if ();

  debug_frame_rx #(
    .FRAME_BYTES   (FB),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .uart       (u_if),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          rd_count = 0;
  logic        prev_rd = 1'b0;
  logic [31:0] prev_fd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and protocol monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (u_if.rd_uart) begin
        rd_count++;
        check("rd_uart_back_to_back", {31'd0, prev_rd}, 32'd0);
      end
      if (frame_valid || frame_err) begin
        check("valid_err_exclusive", {31'd0, frame_valid & frame_err}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_frame_event", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("event_kind_err", {31'd0, frame_err}, {31'd0, e.err});
          if (!e.err) check("sb_frame_data", frame_data, e.data);
        end
      end
      if (!frame_valid && frame_data !== prev_fd)
        check("frame_data_stable", frame_data, prev_fd);
    end
    prev_rd <= u_if.rd_uart;
    prev_fd <= frame_data;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clock);
    u_if.r_data   = b;
    u_if.rx_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!u_if.rd_uart && n < 10);
    if (!u_if.rd_uart) check("rd_uart_wait_expired", 32'd0, 32'd1);
    u_if.rx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] d, input bit corrupt);
    logic [7:0] c;
    exp_t       e;
    c = d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    send_byte(8'hA5);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
    e.err  = corrupt;
    e.data = d;
    sb.push_back(e);
    send_byte(corrupt ? (c ^ 8'h01) : c);
    check("latency_valid", {31'd0, frame_valid}, {31'd0, !corrupt});
    check("latency_err",   {31'd0, frame_err},   {31'd0, corrupt});
  endtask

  initial begin
    int         rc0;
    int         cyc;
    logic [7:0] bytes[6];
    exp_t       e;

    reset         = 1'b1;
    u_if.r_data   = 8'h00;
    u_if.rx_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy",        {31'd0, busy},         32'd0);
    check("reset_rd_uart",     {31'd0, u_if.rd_uart}, 32'd0);
    check("reset_frame_valid", {31'd0, frame_valid},  32'd0);
    check("reset_frame_err",   {31'd0, frame_err},    32'd0);
    check("reset_frame_data",  frame_data,            32'd0);
    @(negedge clock);
    reset = 1'b0;

    // 1: good frame
    rc0 = rd_count;
    send_frame(32'h11223344, 1'b0);
    @(negedge clock); #1;
    check("s1_rd_count", rd_count - rc0, 32'd6);
    check("s1_frame_data", frame_data, 32'h11223344);
    check("s1_busy", {31'd0, busy}, 32'd0);

    // 2: bad checksum keeps previous data
    send_frame(32'h55667788, 1'b1);
    @(negedge clock); #1;
    check("s2_frame_data_kept", frame_data, 32'h11223344);

    // 3: junk before SYNC is dropped
    rc0 = rd_count;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    @(negedge clock); #1;
    check("s3_junk_consumed", rd_count - rc0, 32'd3);
    check("s3_idle_after_junk", {31'd0, busy}, 32'd0);
    send_frame(32'h01020304, 1'b0);
    @(negedge clock); #1;
    check("s3_frame_data", frame_data, 32'h01020304);

    // 4: inter-byte timeout, then recovery
    send_byte(8'hA5);
    send_byte(8'h01);
    check("s4_busy_mid_frame", {31'd0, busy}, 32'd1);
    e.err  = 1'b1;
    e.data = '0;
    sb.push_back(e);
    cyc = 0;
    do begin
      @(posedge clock); #1;
      cyc++;
    end while (!frame_err && cyc < 40);
    check("s4_timeout_cycles", cyc, TO);
    check("s4_busy_after_timeout", {31'd0, busy}, 32'd0);
    send_frame(32'hDEADBEEF, 1'b0);
    @(negedge clock); #1;
    check("s4_recovery_data", frame_data, 32'hDEADBEEF);

    // 5: rx_ready held high across the whole frame
    bytes = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    e.err  = 1'b0;
    e.data = 32'h11223344;
    sb.push_back(e);
    @(negedge clock);
    u_if.r_data   = bytes[0];
    u_if.rx_ready = 1'b1;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      int n;
      n = 0;
      do begin
        @(posedge clock); #1;
        n++;
        cyc++;
      end while (!u_if.rd_uart && n < 10);
      if (!u_if.rd_uart) check("s5_rd_wait_expired", 32'd0, 32'd1);
      if (i < 5) u_if.r_data = bytes[i+1];
    end
    check("s5_valid_latency", {31'd0, frame_valid}, 32'd1);
    u_if.rx_ready = 1'b0;
    check("s5_alternate_cycles", cyc, 32'd11);
    @(negedge clock); #1;
    check("s5_frame_data", frame_data, 32'h11223344);

    // 6: reset mid-frame aborts silently
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    check("s6_busy_before_reset", {31'd0, busy}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("s6_busy_reset", {31'd0, busy}, 32'd0);
    check("s6_frame_data_reset", frame_data, 32'd0);
    check("s6_no_err_on_reset", {31'd0, frame_err}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (TO + 5) @(posedge clock);
    send_frame(32'hAABBCCDD, 1'b0);
    @(negedge clock); #1;
    check("s6_frame_data", frame_data, 32'hAABBCCDD);

    repeat (4) @(posedge clock);
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: observed=expired expected=finished");
    $fatal(1, "time limit");
  end

endmodule
